// File: rtl/dcache_wb_pkg.sv
// Shared types and helpers for the write-back data cache: FSM state,
// cpu_size encodings and the byte-lane decode used for stores.
package dcache_wb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    UPDATE    = 2'd3
  } dcache_state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Size 2'b11 falls into the default arm everywhere, so it behaves as a word.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  misaligned = 1'b0;
      SIZE_H:  misaligned = off[0];
      default: misaligned = (off != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  byte_enable = 4'b0001 << off;
      SIZE_H:  byte_enable = off[1] ? 4'b1100 : 4'b0011;
      default: byte_enable = 4'b1111;
    endcase
  endfunction

  // Replicate low-aligned store data onto every lane; byte enables pick the live ones.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SIZE_B:  store_lanes = {4{wdata[7:0]}};
      SIZE_H:  store_lanes = {2{wdata[15:0]}};
      default: store_lanes = wdata;
    endcase
  endfunction

endpackage

// File: rtl/dcache_line_ram.sv
// Cache data store: LINES x WORDS x 32 bits, combinational read port and a
// byte-enabled synchronous write port. Contents are deliberately not reset.
module dcache_line_ram #(
  parameter int LINES = 64,
  parameter int WORDS = 4,
  parameter int IDX_W = $clog2(LINES),
  parameter int WRD_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_line,
  input  logic [WRD_W-1:0] rd_word,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_line,
  input  logic [WRD_W-1:0] wr_word,
  input  logic [3:0]       wr_be,
  input  logic [31:0]      wr_data
);

  logic [31:0] mem [LINES*WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[{wr_line, wr_word}][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_data = mem[{rd_line, rd_word}];

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache with a one-beat-per-word
// memory bus: dirty victims are written back before the new line is refilled.
module dcache_wb
  import dcache_wb_pkg::*;
#(
  parameter int LINES = 64,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_addr_err,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int IDX_W = $clog2(LINES);
  localparam int WRD_W = $clog2(WORDS);
  localparam int TAG_W = 30 - IDX_W - WRD_W;

  dcache_state_t state, next_state;

  logic [WRD_W-1:0] beat;
  logic [LINES-1:0] valid, dirty;
  logic [TAG_W-1:0] tag_mem [LINES];
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;

  logic [1:0]       cpu_off;
  logic [WRD_W-1:0] cpu_word;
  logic [IDX_W-1:0] cpu_idx;
  logic [TAG_W-1:0] cpu_tag;

  logic lookup, tag_match, hit, miss, last_beat;

  logic [IDX_W-1:0] ram_rd_line, ram_wr_line;
  logic [WRD_W-1:0] ram_rd_word, ram_wr_word;
  logic [31:0]      ram_rd_data, ram_wr_data;
  logic [3:0]       ram_wr_be;
  logic             ram_wr_en;

  assign cpu_off  = cpu_addr[1:0];
  assign cpu_word = cpu_addr[2 +: WRD_W];
  assign cpu_idx  = cpu_addr[2+WRD_W +: IDX_W];
  assign cpu_tag  = cpu_addr[31 -: TAG_W];

  assign cpu_addr_err = cpu_req & misaligned(cpu_size, cpu_off);
  assign lookup       = cpu_req & ~cpu_addr_err & (state == IDLE);
  assign tag_match    = valid[cpu_idx] & (tag_mem[cpu_idx] == cpu_tag);
  assign hit          = lookup & tag_match;
  assign miss         = lookup & ~tag_match;
  assign last_beat    = (beat == WRD_W'(WORDS-1));

  // Bursts address through the latched miss line so the CPU may drop its request.
  assign mem_addr = {(state == WRITEBACK) ? tag_mem[miss_idx] : miss_tag, miss_idx, beat, 2'b00};

  always_comb begin
    next_state = state;
    cpu_stall  = (state != IDLE);
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    case (state)
      IDLE: begin
        if (miss) begin
          cpu_stall  = 1'b1;
          next_state = (valid[cpu_idx] & dirty[cpu_idx]) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        mem_req = 1'b1;
        mem_wr  = 1'b1;
        if (mem_ack && last_beat) next_state = REFILL;
      end
      REFILL: begin
        mem_req = 1'b1;
        if (mem_ack && last_beat) next_state = UPDATE;
      end
      UPDATE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Read port serves the CPU in IDLE and streams the victim line during writeback.
  always_comb begin
    ram_rd_line = (state == IDLE) ? cpu_idx : miss_idx;
    ram_rd_word = (state == IDLE) ? cpu_word : beat;
    ram_wr_en   = (hit & cpu_wr) | ((state == REFILL) & mem_ack);
    ram_wr_line = cpu_idx;
    ram_wr_word = cpu_word;
    ram_wr_be   = byte_enable(cpu_size, cpu_off);
    ram_wr_data = store_lanes(cpu_size, cpu_wdata);
    if (state == REFILL) begin
      ram_wr_line = miss_idx;
      ram_wr_word = beat;
      ram_wr_be   = 4'b1111;
      ram_wr_data = mem_rdata;
    end
  end

  assign cpu_rdata = ram_rd_data;
  assign mem_wdata = ram_rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat     <= '0;
      valid    <= '0;
      dirty    <= '0;
      miss_idx <= '0;
      miss_tag <= '0;
    end else begin
      state <= next_state;
      if (((state == WRITEBACK) || (state == REFILL)) && mem_ack) beat <= beat + WRD_W'(1);
      if (miss) begin
        miss_idx <= cpu_idx;
        miss_tag <= cpu_tag;
      end
      if (state == UPDATE) begin
        valid[miss_idx] <= 1'b1;
        dirty[miss_idx] <= 1'b0;
      end else if (hit && cpu_wr) begin
        dirty[cpu_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == UPDATE) tag_mem[miss_idx] <= miss_tag;
  end

  dcache_line_ram #(
    .LINES(LINES),
    .WORDS(WORDS)
  ) u_line_ram (
    .clk     (clk),
    .rd_line (ram_rd_line),
    .rd_word (ram_rd_word),
    .rd_data (ram_rd_data),
    .wr_en   (ram_wr_en),
    .wr_line (ram_wr_line),
    .wr_word (ram_wr_word),
    .wr_be   (ram_wr_be),
    .wr_data (ram_wr_data)
  );

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb: miss/writeback/refill sequences, a table of
// single-cycle hit and misalignment vectors, and reset in the middle of a refill.
module tb_dcache_wb;
  import dcache_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_wr;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall, cpu_addr_err;
  logic        mem_req, mem_wr, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_model [0:1023];
  logic        throttle = 1'b0;
  logic        ack_phase = 1'b1;

  logic        beat_wr   [0:255];
  logic [31:0] beat_addr [0:255];
  logic [31:0] beat_data [0:255];
  int          nbeats = 0;

  logic        pend = 1'b0;
  logic [31:0] pend_addr, pend_data;
  int          stab_checks = 0;
  int          stab_err = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [18];

  dcache_wb #(.LINES(64), .WORDS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req      (cpu_req),
    .cpu_wr       (cpu_wr),
    .cpu_size     (cpu_size),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_stall    (cpu_stall),
    .cpu_addr_err (cpu_addr_err),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_ack   = mem_req & ack_phase;
  assign mem_rdata = mem_model[mem_addr[11:2]];

  always @(posedge clk) ack_phase <= throttle ? ~ack_phase : 1'b1;

  // Memory model and bus monitor: log every accepted beat, and check that a
  // pending beat keeps its address/data until it is acknowledged.
  always @(negedge clk) begin
    if (rst) begin
      pend <= 1'b0;
    end else begin
      if (pend && mem_req) begin
        stab_checks <= stab_checks + 1;
        if (mem_addr !== pend_addr || (mem_wr && mem_wdata !== pend_data)) stab_err <= stab_err + 1;
      end
      if (mem_req && mem_ack) begin
        beat_wr[nbeats]   <= mem_wr;
        beat_addr[nbeats] <= mem_addr;
        beat_data[nbeats] <= mem_wr ? mem_wdata : mem_rdata;
        nbeats            <= nbeats + 1;
        if (mem_wr) mem_model[mem_addr[11:2]] <= mem_wdata;
      end
      pend      <= mem_req & ~mem_ack;
      pend_addr <= mem_addr;
      pend_data <= mem_wdata;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic req, input logic wr, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata);
    cpu_req   = req;
    cpu_wr    = wr;
    cpu_size  = size;
    cpu_addr  = addr;
    cpu_wdata = wdata;
  endtask

  // Called just after a rising edge; returns after the access completes.
  task automatic do_access(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, output int stalls, output logic [31:0] rdata);
    logic done;
    done   = 1'b0;
    stalls = 0;
    rdata  = '0;
    apply_stimulus(1'b1, wr, size, addr, wdata);
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk); #1;
      if (!cpu_stall) begin
        done  = 1'b1;
        rdata = cpu_rdata;
      end else begin
        stalls++;
        @(posedge clk); #1;
      end
    end
    check_output($sformatf("access_done_%08h", addr), {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic check_beats(input string nm, input int base, input logic wr, input logic [31:0] a0,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] exp_d [4];
    exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
    for (int k = 0; k < 4; k++) begin
      check_output($sformatf("%s_wr%0d", nm, k), {31'd0, beat_wr[base+k]}, {31'd0, wr});
      check_output($sformatf("%s_addr%0d", nm, k), beat_addr[base+k], a0 + 32'(4*k));
      check_output($sformatf("%s_data%0d", nm, k), beat_data[base+k], exp_d[k]);
    end
  endtask

  task automatic set_vec(input int i, input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic exp_err, input logic chk_rd,
                         input logic [31:0] exp_rd);
    vecs[i].wr = wr; vecs[i].size = size; vecs[i].addr = addr; vecs[i].wdata = wdata;
    vecs[i].exp_err = exp_err; vecs[i].chk_rd = chk_rd; vecs[i].exp_rd = exp_rd;
  endtask

  initial begin
    int          stalls, base;
    logic [31:0] rd;
    logic        found;

    for (int i = 0; i < 1024; i++) mem_model[i] = 32'h0;
    mem_model[32'h100 >> 2] = 32'h11; mem_model[32'h104 >> 2] = 32'h22;
    mem_model[32'h108 >> 2] = 32'h33; mem_model[32'h10C >> 2] = 32'h44;
    mem_model[32'h500 >> 2] = 32'h55; mem_model[32'h504 >> 2] = 32'h66;
    mem_model[32'h508 >> 2] = 32'h77; mem_model[32'h50C >> 2] = 32'h88;

    // Hits and misaligned accesses on the line holding 0x500..0x50C.
    set_vec(0,  0, SIZE_W, 32'h500, 32'h0,        0, 1, 32'h0000_0055);
    set_vec(1,  0, SIZE_H, 32'h503, 32'h0,        1, 0, 32'h0);
    set_vec(2,  0, SIZE_W, 32'h502, 32'h0,        1, 0, 32'h0);
    set_vec(3,  1, SIZE_H, 32'h501, 32'hFFFF,     1, 0, 32'h0);
    set_vec(4,  0, SIZE_W, 32'h500, 32'h0,        0, 1, 32'h0000_0055);
    set_vec(5,  1, SIZE_B, 32'h503, 32'hC3,       0, 0, 32'h0);
    set_vec(6,  0, SIZE_B, 32'h500, 32'h0,        0, 1, 32'hC300_0055);
    set_vec(7,  1, SIZE_H, 32'h506, 32'hBEEF,     0, 0, 32'h0);
    set_vec(8,  0, SIZE_W, 32'h504, 32'h0,        0, 1, 32'hBEEF_0066);
    set_vec(9,  1, SIZE_W, 32'h506, 32'hFFFF_FFFF, 1, 0, 32'h0);
    set_vec(10, 0, SIZE_H, 32'h504, 32'h0,        0, 1, 32'hBEEF_0066);
    set_vec(11, 1, SIZE_W, 32'h508, 32'h0102_0304, 0, 0, 32'h0);
    set_vec(12, 0, SIZE_H, 32'h50A, 32'h0,        0, 1, 32'h0102_0304);
    set_vec(13, 1, 2'b11,  32'h50C, 32'hA5A5_A5A5, 0, 0, 32'h0);
    set_vec(14, 0, SIZE_W, 32'h50C, 32'h0,        0, 1, 32'hA5A5_A5A5);
    set_vec(15, 1, SIZE_B, 32'h501, 32'hFFFF_FF7E, 0, 0, 32'h0);
    set_vec(16, 0, SIZE_B, 32'h502, 32'h0,        0, 1, 32'hC300_7E55);
    set_vec(17, 0, 2'b11,  32'h50E, 32'h0,        1, 0, 32'h0);

    rst = 1'b1;
    apply_stimulus(1'b0, 1'b0, SIZE_W, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_output("reset_stall", {31'd0, cpu_stall}, 32'd0);
    check_output("reset_mem_req", {31'd0, mem_req}, 32'd0);
    check_output("reset_addr_err", {31'd0, cpu_addr_err}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] cold miss on 0x100");
    base = nbeats;
    do_access(1'b0, SIZE_W, 32'h100, 32'h0, stalls, rd);
    check_output("cold_stalls", stalls, 32'd6);
    check_output("cold_nbeats", nbeats - base, 32'd4);
    check_beats("cold_refill", base, 1'b0, 32'h100, 32'h11, 32'h22, 32'h33, 32'h44);
    check_output("cold_rdata", rd, 32'h11);

    $display("[TB] store byte hit then load");
    base = nbeats;
    do_access(1'b1, SIZE_B, 32'h102, 32'hAB, stalls, rd);
    check_output("stb_stalls", stalls, 32'd0);
    do_access(1'b0, SIZE_W, 32'h100, 32'h0, stalls, rd);
    check_output("ldhit_stalls", stalls, 32'd0);
    check_output("ldhit_rdata", rd, 32'h00AB_0011);
    check_output("hit_nbeats", nbeats - base, 32'd0);

    $display("[TB] dirty conflict miss on 0x500");
    base = nbeats;
    do_access(1'b0, SIZE_W, 32'h500, 32'h0, stalls, rd);
    check_output("evict_stalls", stalls, 32'd10);
    check_output("evict_nbeats", nbeats - base, 32'd8);
    check_beats("evict_wb", base, 1'b1, 32'h100, 32'h00AB_0011, 32'h22, 32'h33, 32'h44);
    check_beats("evict_refill", base + 4, 1'b0, 32'h500, 32'h55, 32'h66, 32'h77, 32'h88);
    check_output("evict_rdata", rd, 32'h55);

    $display("[TB] vector table");
    base = nbeats;
    for (int i = 0; i < 18; i++) begin
      apply_stimulus(1'b1, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata);
      @(negedge clk); #1;
      check_output($sformatf("vec%0d_err", i), {31'd0, cpu_addr_err}, {31'd0, vecs[i].exp_err});
      check_output($sformatf("vec%0d_stall", i), {31'd0, cpu_stall}, 32'd0);
      check_output($sformatf("vec%0d_mem_req", i), {31'd0, mem_req}, 32'd0);
      if (vecs[i].chk_rd) check_output($sformatf("vec%0d_rdata", i), cpu_rdata, vecs[i].exp_rd);
      @(posedge clk); #1;
    end
    cpu_req = 1'b0;
    check_output("vec_nbeats", nbeats - base, 32'd0);

    $display("[TB] throttled writeback and refill");
    throttle = 1'b1;
    base = nbeats;
    do_access(1'b0, SIZE_W, 32'h100, 32'h0, stalls, rd);
    throttle = 1'b0;
    check_output("thr_nbeats", nbeats - base, 32'd8);
    check_beats("thr_wb", base, 1'b1, 32'h500, 32'hC300_7E55, 32'hBEEF_0066, 32'h0102_0304, 32'hA5A5_A5A5);
    check_beats("thr_refill", base + 4, 1'b0, 32'h100, 32'h00AB_0011, 32'h22, 32'h33, 32'h44);
    check_output("thr_rdata", rd, 32'h00AB_0011);
    check_output("stab_seen", {31'd0, stab_checks != 0}, 32'd1);
    check_output("stab_err", stab_err, 32'd0);
    @(posedge clk); #1;

    $display("[TB] reset during refill beat 2");
    base  = nbeats;
    found = 1'b0;
    apply_stimulus(1'b1, 1'b0, SIZE_W, 32'h500, 32'h0);
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk); #1;
      if (mem_req && (nbeats - base == 3)) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check_output("rst_reached_beat2", {31'd0, found}, 32'd1);
    check_output("rst_beat2_addr", mem_addr, 32'h508);
    rst = 1'b1;
    cpu_req = 1'b0;
    #1;
    check_output("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_output("rst_stall", {31'd0, cpu_stall}, 32'd0);
    @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    base = nbeats;
    do_access(1'b0, SIZE_W, 32'h100, 32'h0, stalls, rd);
    check_output("post_rst_100_stalls", stalls, 32'd6);
    check_output("post_rst_100_nbeats", nbeats - base, 32'd4);
    check_output("post_rst_100_rdata", rd, 32'h00AB_0011);

    base = nbeats;
    do_access(1'b0, SIZE_W, 32'h500, 32'h0, stalls, rd);
    check_output("retry_stalls", stalls, 32'd6);
    check_output("retry_nbeats", nbeats - base, 32'd4);
    check_beats("retry_refill", base, 1'b0, 32'h500, 32'hC300_7E55, 32'hBEEF_0066, 32'h0102_0304, 32'hA5A5_A5A5);
    check_output("retry_rdata", rd, 32'hC300_7E55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_wb.md
DCACHE_WB -- requirements
Module: dcache_wb

Interface
REQ-001 Parameter LINES, default 64, number of direct-mapped lines (power of 2, >=2).
REQ-002 Parameter WORDS, default 4, 32-bit words per line (power of 2, >=2).
REQ-003 Port clk  in  1  sole clock, all state updates on rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-high.
REQ-005 Port cpu_req  in  1  access request this cycle.
REQ-006 Port cpu_wr  in  1  1=store, 0=load.
REQ-007 Port cpu_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-008 Port cpu_addr  in  32  byte address.
REQ-009 Port cpu_wdata  in  32  store data, low-aligned (byte in [7:0], half in [15:0]).
REQ-010 Port cpu_rdata  out  32  full aligned word at cpu_addr; sign/zero extension done downstream.
REQ-011 Port cpu_stall  out  1  access not complete; CPU holds all cpu_* inputs stable.
REQ-012 Port cpu_addr_err  out  1  misaligned access (half with addr[0]=1, word with addr[1:0]!=0).
REQ-013 Port mem_req  out  1  bus beat request.
REQ-014 Port mem_wr  out  1  1=writeback beat, 0=refill beat.
REQ-015 Port mem_addr  out  32  word-aligned beat address.
REQ-016 Port mem_wdata  out  32  writeback data.
REQ-017 Port mem_ack  in  1  beat accepted; for reads mem_rdata valid same cycle.
REQ-018 Port mem_rdata  in  32  refill data.

Function
REQ-019 Address split: offset [1:0], word index log2(WORDS) bits, line index log2(LINES) bits, remaining upper bits tag.
REQ-020 Per line: valid, dirty, tag, WORDS data words; write-back, write-allocate.
REQ-021 cpu_addr_err is combinational; misaligned request causes no lookup, no stall, no state or memory change.
REQ-022 Hit (IDLE, cpu_req, valid, tag match, aligned): cpu_stall=0 same cycle, cpu_rdata combinational; store writes selected bytes at next edge and sets dirty.
REQ-023 Store byte lanes: byte -> lane addr[1:0]; half -> lanes {addr[1],0} and {addr[1],1}; word -> all four.
REQ-024 Miss: cpu_stall=1 combinationally in the same cycle; FSM leaves IDLE at next edge.
REQ-025 States IDLE, WRITEBACK, REFILL, UPDATE; miss on dirty valid line -> WRITEBACK, else -> REFILL.
REQ-026 WRITEBACK: mem_req=1, mem_wr=1, mem_addr={old tag,index,beat,2'b00}, beat counter advances on mem_ack; after beat WORDS-1 acked -> REFILL, counter wraps to 0.
REQ-027 REFILL: mem_req=1, mem_wr=0, mem_addr={new tag,index,beat,2'b00}; each acked word written to line; after last beat -> UPDATE, counter to 0.
REQ-028 UPDATE: valid=1, dirty=0, tag written; next state IDLE; cpu_stall stays 1 through UPDATE; access then hits in IDLE.
REQ-029 mem_req never asserted in IDLE or UPDATE; mem_addr, mem_wdata stable while mem_req=1 and mem_ack=0.
REQ-030 cpu_req deasserted during a miss: in-progress writeback/refill still completes.
REQ-031 cpu_rdata when not hit: don't-care, verification checks only when cpu_req & ~cpu_stall & ~cpu_addr_err.

Reset
REQ-032 rst asserted at any time, including mid-burst: state IDLE, beat counter 0, all valid and dirty cleared, mem_req=0, cpu_stall=0 while cpu_req=0.
REQ-033 Data and tag arrays are not reset.

Structure
REQ-034 Shared package holds state enum dcache_state_t and cpu_size encodings (SIZE_B, SIZE_H, SIZE_W).
REQ-035 One sub-module dcache_line_ram: LINES x WORDS x 32 storage, combinational read, 4-bit byte-enable synchronous write.

Verification
REQ-036 After reset, load word 0x0000_0100 with mem returning 0x11,0x22,0x33,0x44 -> 4 read beats at 0x100..0x10C, stall 6 cycles total with ack each cycle, rdata=0x11.
REQ-037 Store byte 0xAB to 0x0000_0102 after refill, then load word 0x100 -> hit, no stall, rdata=0x00AB_0011.
REQ-038 Load 0x0000_0100+LINES*WORDS*4 (same index, new tag) -> 4 write beats at 0x100..0x10C with data 0x00AB0011,0x22,0x33,0x44, then 4 read beats.
REQ-039 Load half at 0x0000_0103 and word at 0x0000_0102 -> cpu_addr_err=1, cpu_stall=0, mem_req stays 0.
REQ-040 Assert rst during REFILL beat 2 -> mem_req drops immediately; repeat original load -> full miss (4 refill beats), not a hit.
